// File: rtl/strm_mux_pkg.sv
// Shared constants and the round-robin pick function for streaming muxes/arbiters.
package strm_mux_pkg;

  localparam int STRM_MUX_N_CH_DEF   = 4;
  localparam int STRM_MUX_DATA_W_DEF = 8;

  // rr_pick works on a fixed-width request vector so any arbiter up to RR_MAX_CH can share it.
  localparam int RR_MAX_CH = 32;
  localparam int RR_IDX_W  = $clog2(RR_MAX_CH);

  typedef logic [RR_MAX_CH-1:0] rr_vec_t;

  // One-hot grant for the first request found scanning ptr+1, ptr+2, ... modulo n_ch.
  function automatic rr_vec_t rr_pick(input rr_vec_t req, input int unsigned ptr,
                                      input int unsigned n_ch);
    rr_vec_t             gnt;
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
      idx = RR_IDX_W'((ptr + k) % n_ch);
      if (k <= n_ch && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/strm_mux_rr_arbiter.sv
// Round-robin arbiter with an optional lock that pins the grant to one channel.
module rr_arbiter
  import strm_mux_pkg::*;
#(
  parameter  int N_CH = STRM_MUX_N_CH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            lock,
  input  logic [CH_W-1:0] lock_ch,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  rr_vec_t rr_wide;
  logic    unused_rr_hi;

  always_comb begin
    rr_wide = rr_pick(rr_vec_t'(req), 32'(ptr), N_CH);
    gnt     = '0;
    // A locked channel that drops valid simply gets no grant; nobody else may take its slot.
    if (lock) begin
      gnt[lock_ch] = req[lock_ch];
    end else begin
      gnt = rr_wide[N_CH-1:0];
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) gnt_idx = CH_W'(i);
    end
  end

  assign unused_rr_hi = ^rr_wide;

endmodule

// File: rtl/strm_mux_rr.sv
// N-channel round-robin stream mux with a one-deep registered output and optional packet lock.
// Define STRM_MUX_FORCE_SEL_EN to add force_en/force_sel static channel selection.
module strm_mux_rr
  import strm_mux_pkg::*;
#(
  parameter  int N_CH     = STRM_MUX_N_CH_DEF,
  parameter  int DATA_W   = STRM_MUX_DATA_W_DEF,
  parameter  int PKT_MODE = 0,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [CH_W-1:0]        out_ch,
  input  logic                   out_ready
`ifdef STRM_MUX_FORCE_SEL_EN
  ,
  input  logic                   force_en,
  input  logic [CH_W-1:0]        force_sel
`endif
);

  logic [CH_W-1:0]   ptr_reg;
  logic              lock_reg;
  logic [CH_W-1:0]   lock_ch_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_last_reg;
  logic [CH_W-1:0]   out_ch_reg;

  logic [N_CH-1:0]   req;
  logic              arb_lock;
  logic [N_CH-1:0]   gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] ch_data [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef STRM_MUX_FORCE_SEL_EN
  // An out-of-range force_sel matches no channel, so nothing is granted.
  logic [N_CH-1:0] force_mask;
  always_comb begin
    force_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (force_sel == CH_W'(i)) force_mask[i] = 1'b1;
    end
  end
  assign req      = force_en ? (in_valid & force_mask) : in_valid;
  assign arb_lock = lock_reg && !force_en;
`else
  assign req      = in_valid;
  assign arb_lock = lock_reg;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .lock    (arb_lock),
    .lock_ch (lock_ch_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Load when empty or when the current beat leaves this same cycle.
  assign load_en  = !out_valid_reg || out_ready;
  assign in_ready = (load_en && !rst) ? gnt : '0;
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_ch_reg    <= '0;
      ptr_reg       <= CH_W'(N_CH - 1);
      lock_reg      <= 1'b0;
      lock_ch_reg   <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ch_data[gnt_idx];
      out_last_reg  <= in_last[gnt_idx];
      out_ch_reg    <= gnt_idx;
      ptr_reg       <= gnt_idx;
      lock_reg      <= (PKT_MODE != 0) && !in_last[gnt_idx];
      lock_ch_reg   <= gnt_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: doc/strm_mux_rr.md
Name: strm_mux_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer. It is the registered, handshaked successor to the team's 4:1 combinational mux.
- Each input channel presents valid/data/last. A round-robin arbiter picks one channel per beat and forwards the beat through a one-deep output register with valid/ready backpressure.
- Optional packet mode holds the grant on one channel until its last beat.
- Sits between multiple producer streams and a single shared consumer (e.g. UART TX, result bus).

Parameters:
- N_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- PKT_MODE, 0, 1 = grant locked until in_last beat is accepted; 0 = arbitration every beat.
- CH_W, $clog2(N_CH), derived localparam; width of channel index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_CH  per-channel beat valid.
- in_data  in  N_CH*DATA_W  packed channel data; channel i at [i*DATA_W +: DATA_W].
- in_last  in  N_CH  per-channel end-of-packet flag (ignored when PKT_MODE=0).
- in_ready  out  N_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output data.
- out_last  out  1  forwarded last flag.
- out_ch  out  CH_W  index of the channel that sourced out_data.
- out_ready  in  1  consumer accept.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0. rr pointer ptr=N_CH-1, so channel 0 has first priority. lock=0. in_ready=0 while rst is high.
- load_en = !out_valid || out_ready. The output register loads when empty or being drained in the same cycle.
- Arbitration (combinational):
  - If lock=1, grant = locked channel only.
  - Otherwise, grant = first channel with in_valid=1 scanning ptr+1, ptr+2, ... modulo N_CH (wrap-around).
- in_ready[g] = load_en && in_valid[g] for the granted g; all other bits are 0.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - Next cycle: out_valid=1, out_data=in_data[g], out_last=in_last[g], out_ch=g.
  - ptr <= g.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- Drain without refill (out_ready=1 and no transfer): out_valid <= 0. out_data, out_last and out_ch hold their last values.
- Backpressure (out_valid=1, out_ready=0): output register holds; all in_ready=0; ptr and lock unchanged.
- PKT_MODE=1:
  - A transfer with in_last=0 sets lock=1 on that channel.
  - A transfer with in_last=1 clears lock.
  - While locked, the locked channel may deassert in_valid (a bubble); the grant does not move.
- PKT_MODE=0: lock is held at 0 permanently.
- No in_valid asserted: no grant, ptr unchanged.
- Simultaneous drain and load: legal, no bubble.
- Reset mid-packet: lock is cleared, ptr=N_CH-1, any in-flight output beat is discarded.
- Input rule: in_data and in_last must be stable while in_valid=1 and in_ready=0. This is the producer's obligation and is not checked.

Optional Feature:
- STRM_MUX_FORCE_SEL_EN.
- When defined, adds ports force_en (in, 1) and force_sel (in, CH_W).
- While force_en=1, the grant is restricted to channel force_sel (a legacy static-select mode), and the rr pointer still updates on each transfer.
- If force_sel >= N_CH, no channel is granted.
- force_en overrides lock.
- When not defined, the ports are absent and arbitration is pure round-robin/lock.

Decomposition:
- Package strm_mux_pkg:
  - Default constants STRM_MUX_N_CH_DEF=4 and STRM_MUX_DATA_W_DEF=8.
  - Function rr_pick(req, ptr) returning the one-hot grant, shared with future arbiters.
- One sub-module: rr_arbiter (req, ptr, lock, lock_ch -> one-hot grant, grant index).
- strm_mux_rr owns the output register, ptr and lock state.

Test Plan:
1. Reset and single channel: rst for 2 cycles, then in_valid=4'b0001, in_data ch0=8'hA5, out_ready=1 → cycle after transfer: out_valid=1, out_data=A5, out_ch=0; all outputs 0 during reset.
2. Round-robin fairness: all 4 channels valid continuously, data = 8'h10+i, out_ready=1 → out_ch sequence 0,1,2,3,0,1,…; 1 beat/cycle, no bubbles.
3. Backpressure: stream running, out_ready=0 for 3 cycles → out_data held, in_ready=4'b0000, ptr frozen; out_ready=1 → sequence resumes with no loss or duplication.
4. Wrap-around and skip: ptr=3, only ch1 and ch2 valid → ch1 granted then ch2; ch0 and ch3 never appear on out_ch.
5. PKT_MODE=1: ch2 sends a 3-beat packet (last on beat 3) while ch0 is also valid → out_ch=2,2,2 with out_last on beat 3, then out_ch=0. Repeat with a 1-cycle in_valid gap on ch2 mid-packet → grant stays on ch2.
6. STRM_MUX_FORCE_SEL_EN: force_en=1, force_sel=2'd3, all channels valid → only ch3 beats appear. force_sel out of range (N_CH=3, force_sel=3) → no transfers. Reset asserted mid-packet → out_valid=0 next cycle and lock cleared.
